e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the 5-stage MIPS pipeline. It sits downstream of decode control and receives the decoded MDU operation and forwarded rs/rt values from the D/E register. It models multi-cycle mult/multu/div/divu and owns the HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Exports `E_Busy`/`E_Start` so the hazard logic can stall any D-stage instruction whose HILO_operation is 1 while the unit is occupied.

---
 rtl/e_mdu_pkg.sv | 38 +++
 rtl/e_mdu_calc.sv | 66 ++++++
 rtl/e_mdu.sv | 110 +++++++++++
 tb/tb_e_mdu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: constants shared by decode control and the execute-stage MDU.
//   - MDU operation codes carried on E_MDUOp (codes 9..15 behave as NONE)
//   - default multi-cycle latencies for multiply and divide
//   - sequencing FSM state type and small op-classification helpers
package e_mdu_pkg;

  localparam int MDU_OP_W = 4;
  typedef logic [MDU_OP_W-1:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 4'd0;
  localparam mdu_op_t MDU_MULT  = 4'd1;
  localparam mdu_op_t MDU_MULTU = 4'd2;
  localparam mdu_op_t MDU_DIV   = 4'd3;
  localparam mdu_op_t MDU_DIVU  = 4'd4;
  localparam mdu_op_t MDU_MFHI  = 4'd5;
  localparam mdu_op_t MDU_MFLO  = 4'd6;
  localparam mdu_op_t MDU_MTHI  = 4'd7;
  localparam mdu_op_t MDU_MTLO  = 4'd8;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles.
  function automatic logic is_start_op(mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// mdu_calc: purely combinational arithmetic core of the MDU.
// Ports:
//   op       in  4  : MDU op code (only MULT/MULTU/DIV/DIVU produce a result)
//   rs, rt   in  32 : operands (rs = multiplicand / dividend)
//   result   out 64 : {hi, lo}; for divides hi = remainder, lo = quotient
//   div_zero out 1  : divide op with rt == 0 (result is then don't-care, 0)
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         rs,
  input  logic [31:0]         rt,
  output logic [63:0]         result,
  output logic                div_zero
);

  logic signed [63:0] sx_rs;
  logic signed [63:0] sx_rt;
  logic [31:0] mag_rs;
  logic [31:0] mag_rt;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  assign sx_rs = {{32{rs[31]}}, rs};
  assign sx_rt = {{32{rt[31]}}, rt};

  // Signed divide is done on magnitudes so -2^31 / -1 stays well defined:
  // the quotient sign is the XOR of operand signs, the remainder follows rs.
  assign mag_rs = rs[31] ? (~rs + 32'd1) : rs;
  assign mag_rt = rt[31] ? (~rt + 32'd1) : rt;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    quo_mag = '0;
    rem_mag = '0;
    if (mag_rt != 32'd0) begin
      quo_mag = mag_rs / mag_rt;
      rem_mag = mag_rs % mag_rt;
    end
  end

  assign quo_s = (rs[31] ^ rt[31]) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_s = rs[31] ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  result = sx_rs * sx_rt;
      MDU_MULTU: result = {32'd0, rs} * {32'd0, rt};
      MDU_DIV: begin
        if (rt == 32'd0) div_zero = 1'b1;
        else             result   = {rem_s, quo_s};
      end
      MDU_DIVU: begin
        if (rt == 32'd0) div_zero = 1'b1;
        else             result   = {rs % rt, rs / rt};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
// A start op computes its result immediately into temp_hi/temp_lo, then the
// unit stays busy for MULT_CYCLES / DIV_CYCLES before committing to HI/LO.
// Ports:
//   clk       in  1  : rising-edge clock
//   reset     in  1  : synchronous active-high reset (aborts any op in flight)
//   E_MDUOp   in  4  : MDU op code
//   E_RS      in  32 : forwarded rs
//   E_RT      in  32 : forwarded rt
//   E_Start   out 1  : combinational, op is MULT/MULTU/DIV/DIVU
//   E_Busy    out 1  : registered, operation in progress
//   E_MDU_out out 32 : HI for MFHI, LO for MFLO, else 0
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] E_MDUOp,
  input  logic [31:0]         E_RS,
  input  logic [31:0]         E_RT,
  output logic                E_Start,
  output logic                E_Busy,
  output logic [31:0]         E_MDU_out
);

  mdu_state_e  state;
  mdu_state_e  state_next;
  logic [3:0]  count;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] temp_hi;
  logic [31:0] temp_lo;
  logic [63:0] calc_result;
  logic        calc_div_zero;
  logic [3:0]  start_latency;
  logic        done;

  mdu_calc u_calc (
    .op       (E_MDUOp),
    .rs       (E_RS),
    .rt       (E_RT),
    .result   (calc_result),
    .div_zero (calc_div_zero)
  );

  assign start_latency = is_div_op(E_MDUOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
  assign done          = (state == ST_RUN) && (count == 4'd1);

  // State register plus HI/LO/temp/counter datapath.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE) begin
        if (is_start_op(E_MDUOp)) begin
          // Divide by zero captures the current HI/LO so the commit at the
          // end of the busy window rewrites them unchanged. HI/LO cannot
          // move meanwhile because everything is ignored while busy.
          temp_hi <= calc_div_zero ? hi : calc_result[63:32];
          temp_lo <= calc_div_zero ? lo : calc_result[31:0];
          count   <= start_latency;
        end else if (E_MDUOp == MDU_MTHI) begin
          hi <= E_RS;
        end else if (E_MDUOp == MDU_MTLO) begin
          lo <= E_RS;
        end
      end else begin
        count <= count - 4'd1;
        if (done) begin
          hi <= temp_hi;
          lo <= temp_lo;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (is_start_op(E_MDUOp)) state_next = ST_RUN;
      ST_RUN:  if (done)                 state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs. MFHI/MFLO issued while busy are ignored like any other op, so
  // the read port returns 0 during the busy window.
  always_comb begin
    E_Start   = is_start_op(E_MDUOp);
    E_Busy    = (state == ST_RUN);
    E_MDU_out = '0;
    if (state == ST_IDLE) begin
      if (E_MDUOp == MDU_MFHI)      E_MDU_out = hi;
      else if (E_MDUOp == MDU_MFLO) E_MDU_out = lo;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu. A behavioural model (remaining-cycle
// count plus pending result, computed with plain integer arithmetic) is
// checked against the DUT every cycle on the falling edge; directed
// sequences add hand-computed literal expectations.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out;

  int compared   = 0;
  int mismatched = 0;
  bit armed      = 1'b0;

  // Behavioural model state.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_write;
  int          m_left;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDUOp   (op),
    .E_RS      (rs),
    .E_RT      (rt),
    .E_Start   (start),
    .E_Busy    (busy),
    .E_MDU_out (mdu_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op issued while idle yields its result and a busy length;
  // the result lands when the remaining count runs out.
  always @(posedge clk) begin
    longint prod;
    int     sa, sb;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; p_write = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_write) begin m_hi = p_hi; m_lo = p_lo; end
    end else begin
      case (op)
        MDU_MULT: begin
          prod = longint'($signed(rs)) * longint'($signed(rt));
          {p_hi, p_lo} = prod; p_write = 1; m_left = 5;
        end
        MDU_MULTU: begin
          prod = longint'({32'd0, rs}) * longint'({32'd0, rt});
          {p_hi, p_lo} = prod; p_write = 1; m_left = 5;
        end
        MDU_DIV: begin
          sa = rs; sb = rt; m_left = 10; p_write = (rt != 0);
          if (rt != 0) begin p_lo = sa / sb; p_hi = sa % sb; end
        end
        MDU_DIVU: begin
          m_left = 10; p_write = (rt != 0);
          if (rt != 0) begin p_lo = rs / rt; p_hi = rs % rt; end
        end
        MDU_MTHI: m_hi = rs;
        MDU_MTLO: m_lo = rs;
        default: ;
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [31:0] exp_out;
    if (armed) begin
      exp_out = 0;
      if (m_left == 0 && op == MDU_MFHI) exp_out = m_hi;
      if (m_left == 0 && op == MDU_MFLO) exp_out = m_lo;
      check("model_busy",  {31'd0, busy},  {31'd0, m_left > 0});
      check("model_start", {31'd0, start}, {31'd0, op >= 4'd1 && op <= 4'd4});
      check("model_out",   mdu_out, exp_out);
    end
  end

  // Present an op for one cycle; returns at posedge+1 of cycle T+1.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs = a; rt = b;
    @(posedge clk); #1;
    op = MDU_NONE; rs = 0; rt = 0;
  endtask

  task automatic count_busy(input string name, input int already, input int exp);
    int n;
    n = already;
    while (busy && n < 40) begin n++; @(posedge clk); #1; end
    check(name, n, exp);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    op = MDU_MFHI; #1 check({name, "_hi"}, mdu_out, eh);
    op = MDU_MFLO; #1 check({name, "_lo"}, mdu_out, el);
    op = MDU_NONE;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    op = MDU_NONE; rs = 0; rt = 0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; armed = 1'b1;

    check("reset_busy", {31'd0, busy}, 32'd0);
    read_hilo("reset", 32'h0, 32'h0);

    // MULT -3 * 7
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_busy_t1", {31'd0, busy}, 32'd1);
    count_busy("mult_busy_len", 0, 5);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // MULTU 0xFFFFFFFF * 2
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy("multu_busy_len", 0, 5);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // DIV -7 / 2
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy("div_busy_len", 0, 10);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU 7 / 2
    issue(MDU_DIVU, 32'd7, 32'd2);
    count_busy("divu_busy_len", 0, 10);
    read_hilo("divu", 32'd1, 32'd3);

    // Preload then divide by zero: HI/LO unchanged.
    issue(MDU_MTHI, 32'h1234, 32'd0);
    issue(MDU_MTLO, 32'h5678, 32'd0);
    read_hilo("mt", 32'h1234, 32'h5678);
    issue(MDU_DIV, 32'd9, 32'd0);
    count_busy("div0_busy_len", 0, 10);
    read_hilo("div0", 32'h1234, 32'h5678);

    // Stall-contract violations during a MULT 5 * 6.
    issue(MDU_MULT, 32'd5, 32'd6);             // now in T+1
    @(posedge clk); #1;                         // T+2: second DIV
    op = MDU_DIV; rs = 32'd100; rt = 32'd7;
    #1 check("start_while_busy", {31'd0, start}, 32'd1);
    @(posedge clk); #1;                         // T+3: MTLO
    op = MDU_MTLO; rs = 32'hAAAA; rt = 0;
    @(posedge clk); #1;                         // T+4: MFHI while busy
    op = MDU_MFHI; rs = 0;
    #1 check("mf_while_busy", mdu_out, 32'd0);
    op = MDU_NONE;
    count_busy("stall_busy_len", 3, 5);
    read_hilo("stall", 32'd0, 32'd30);

    // Reset during a DIV at T+4: result discarded.
    issue(MDU_DIV, 32'd50, 32'd5);              // now in T+1
    repeat (3) begin @(posedge clk); #1; end    // T+4
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    read_hilo("abort_late", 32'd0, 32'd0);

    @(posedge clk); #1;
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
